// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU control decoder and execution unit with registered result,
// valid/ready handshake and an iterative shift-add multiplier with HI/LO.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (transfer on both high)
//   flush               drops the op presented this cycle or an in-flight multiply
//   ALUOp1/ALUOp0       ALUOp from main control
//   funct, shamt        R-type function and shift amount fields
//   a, b                operands (rs, rt/immediate)
//   out_valid           one-cycle pulse per completed op
//   result, zero        registered result and result==0
//   illegal             pulses with out_valid when funct was undefined
//   ctrl_out            registered op code of the last accepted op
//   busy                multiply in progress
module alu_exec_ctrl #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             ALUOp1,
    input  logic             ALUOp0,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [3:0]       ctrl_out,
    output logic             busy
);

    localparam int LW = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MFHI  = 4'b0100;
    localparam logic [3:0] OP_MFLO  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1110;
    localparam logic [3:0] OP_MULTU = 4'b1111;

    logic [0:0]         state;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [LW-1:0]      cnt;
    logic               neg;

    logic [3:0]         op;
    logic               ill;
    logic               is_mul;
    logic [LW-1:0]      sh;
    logic [WIDTH-1:0]   alu;
    logic [WIDTH-1:0]   sra;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic               mneg;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] prod;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state == S_MUL);

    // Undefined functs (and mult-class functs when the multiplier is
    // absent) fall back to ADD and are flagged illegal.
    always_comb begin
        op  = OP_ADD;
        ill = 1'b0;
        unique case ({ALUOp1, ALUOp0})
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b11: op = OP_OR;
            2'b10: begin
                case (funct)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b000000: op = OP_SLL;
                    6'b000010: op = OP_SRL;
                    6'b000011: op = OP_SRA;
                    6'b011000: if (MUL_EN) op = OP_MULT;  else ill = 1'b1;
                    6'b011001: if (MUL_EN) op = OP_MULTU; else ill = 1'b1;
                    6'b010000: if (MUL_EN) op = OP_MFHI;  else ill = 1'b1;
                    6'b010010: if (MUL_EN) op = OP_MFLO;  else ill = 1'b1;
                    default:   ill = 1'b1;
                endcase
            end
        endcase
    end

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign sh     = LW'(shamt);
    assign sra    = $signed(b) >>> sh;

    always_comb begin
        alu = a + b;
        case (op)
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_NOR:  alu = ~(a | b);
            OP_SUB:  alu = a - b;
            OP_SLT:  alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  alu = b << sh;
            OP_SRL:  alu = b >> sh;
            OP_SRA:  alu = sra;
            OP_MFHI: alu = hi;
            OP_MFLO: alu = lo;
            default: alu = a + b;
        endcase
    end

    // Signed multiply runs on magnitudes; the sign is restored at the end.
    always_comb begin
        ma   = a;
        mb   = b;
        mneg = 1'b0;
        if (op == OP_MULT) begin
            if (a[WIDTH-1]) ma = -a;
            if (b[WIDTH-1]) mb = -b;
            mneg = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    assign sum  = acc + (mplier[0] ? mcand : '0);
    assign prod = neg ? -sum : sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
            ctrl_out  <= OP_ADD;
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else if (state == S_IDLE) begin
                if (in_valid) begin
                    ctrl_out <= op;
                    if (is_mul) begin
                        state  <= S_MUL;
                        mcand  <= {{WIDTH{1'b0}}, ma};
                        mplier <= mb;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= mneg;
                    end else begin
                        result    <= alu;
                        zero      <= (alu == '0);
                        illegal   <= ill;
                        out_valid <= 1'b1;
                    end
                end
            end else begin
                acc    <= sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                // Last bit folds straight into the final product.
                if (cnt == LW'(WIDTH-1)) begin
                    hi        <= prod[2*WIDTH-1:WIDTH];
                    lo        <= prod[WIDTH-1:0];
                    result    <= prod[WIDTH-1:0];
                    zero      <= (prod[WIDTH-1:0] == '0);
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed self-checking bench for alu_exec_ctrl (WIDTH=32, MUL_EN=1).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        ALUOp1;
    logic        ALUOp0;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [3:0]  ctrl_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .funct(funct),
        .shamt(shamt), .a(a), .b(b), .out_valid(out_valid),
        .result(result), .zero(zero), .illegal(illegal),
        .ctrl_out(ctrl_out), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] aop, input logic [5:0] f,
                       input logic [4:0] sa, input logic [31:0] av,
                       input logic [31:0] bv);
        in_valid = 1'b1;
        {ALUOp1, ALUOp0} = aop;
        funct = f;
        shamt = sa;
        a = av;
        b = bv;
    endtask

    // Present one op, clock it in, drop in_valid, then check the result.
    task automatic one(input string tag, input logic [1:0] aop,
                       input logic [5:0] f, input logic [4:0] sa,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic [3:0] ec,
                       input logic eill);
        drv(aop, f, sa, av, bv);
        step();
        in_valid = 1'b0;
        chk({tag, ".ov"}, 64'(out_valid), 64'(1'b1));
        chk({tag, ".res"}, 64'(result), 64'(er));
        chk({tag, ".zero"}, 64'(zero), 64'(er == 32'd0));
        chk({tag, ".ctrl"}, 64'(ctrl_out), 64'(ec));
        chk({tag, ".ill"}, 64'(illegal), 64'(eill));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rdy"}, 64'(in_ready), 64'(1'b1));
        chk({tag, ".ov"}, 64'(out_valid), 64'(1'b0));
        chk({tag, ".res"}, 64'(result), 64'(32'd0));
        chk({tag, ".zero"}, 64'(zero), 64'(1'b1));
        chk({tag, ".ill"}, 64'(illegal), 64'(1'b0));
        chk({tag, ".ctrl"}, 64'(ctrl_out), 64'(4'b0010));
        chk({tag, ".busy"}, 64'(busy), 64'(1'b0));
    endtask

    initial begin
        int lowc;
        int lat;
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        drv(2'b00, 6'd0, 5'd0, 32'd0, 32'd0);
        in_valid = 1'b0;
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;

        one("sub", 2'b10, 6'b100010, 5'd0, 32'd5, 32'd7,
            32'hFFFFFFFE, 4'b0110, 1'b0);
        step();
        chk("sub.pulse", 64'(out_valid), 64'(1'b0));

        // back-to-back single-cycle ops
        one("slt", 2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'd1,
            32'd1, 4'b0111, 1'b0);
        one("sra", 2'b10, 6'b000011, 5'd4, 32'd0, 32'h80000000,
            32'hF8000000, 4'b1010, 1'b0);
        one("srl", 2'b10, 6'b000010, 5'd31, 32'd0, 32'h80000000,
            32'd1, 4'b1001, 1'b0);
        one("sll", 2'b10, 6'b000000, 5'd8, 32'd0, 32'h00FF00FF,
            32'hFF00FF00, 4'b1000, 1'b0);
        one("nor", 2'b10, 6'b100111, 5'd0, 32'd0, 32'd0,
            32'hFFFFFFFF, 4'b1100, 1'b0);
        one("xor", 2'b10, 6'b100110, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00,
            32'h0FF00FF0, 4'b0011, 1'b0);
        one("and", 2'b10, 6'b100100, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00,
            32'hF000F000, 4'b0000, 1'b0);
        one("addwrap", 2'b00, 6'b111111, 5'd0, 32'hFFFFFFFF, 32'd1,
            32'd0, 4'b0010, 1'b0);
        one("beq", 2'b01, 6'b000000, 5'd0, 32'd9, 32'd9,
            32'd0, 4'b0110, 1'b0);

        // signed multiply -3 * 7
        drv(2'b10, 6'b011000, 5'd0, 32'hFFFFFFFD, 32'd7);
        step();
        in_valid = 1'b0;
        chk("mult.busy", 64'(busy), 64'(1'b1));
        lowc = 0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (!in_ready) lowc++;
            step();
            lat++;
        end
        chk("mult.lowcyc", 64'(lowc), 64'd32);
        chk("mult.lat", 64'(lat), 64'd33);
        chk("mult.ov", 64'(out_valid), 64'(1'b1));
        chk("mult.res", 64'(result), 64'(32'hFFFFFFEB));
        chk("mult.rdy", 64'(in_ready), 64'(1'b1));
        chk("mult.ctrl", 64'(ctrl_out), 64'(4'b1110));
        step();
        one("mfhi", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0,
            32'hFFFFFFFF, 4'b0100, 1'b0);

        // unsigned multiply aborted by flush at cycle 10
        drv(2'b10, 6'b011001, 5'd0, 32'hFFFFFFFF, 32'd2);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        chk("multu.busy", 64'(busy), 64'(1'b1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush.busy", 64'(busy), 64'(1'b0));
        chk("flush.rdy", 64'(in_ready), 64'(1'b1));
        chk("flush.ov", 64'(out_valid), 64'(1'b0));
        step();
        chk("flush.ov2", 64'(out_valid), 64'(1'b0));
        one("mflo", 2'b10, 6'b010010, 5'd0, 32'd0, 32'd0,
            32'hFFFFFFEB, 4'b0101, 1'b0);
        one("mfhi2", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0,
            32'hFFFFFFFF, 4'b0100, 1'b0);

        // flush in IDLE discards the presented op
        drv(2'b00, 6'd0, 5'd0, 32'd1, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("iflush.ov", 64'(out_valid), 64'(1'b0));
        chk("iflush.ctrl", 64'(ctrl_out), 64'(4'b0100));

        one("illegal", 2'b10, 6'b111111, 5'd0, 32'd3, 32'd4,
            32'd7, 4'b0010, 1'b1);
        one("ori", 2'b11, 6'b000000, 5'd0, 32'h0F0, 32'h00F,
            32'h0FF, 4'b0001, 1'b0);

        // reset during multiply clears HI/LO
        drv(2'b10, 6'b011001, 5'd0, 32'd3, 32'd5);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk_reset("rstmul");
        rst = 1'b0;
        one("mfhi0", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0,
            32'd0, 4'b0100, 1'b0);
        one("mflo0", 2'b10, 6'b010010, 5'd0, 32'd0, 32'd0,
            32'd0, 4'b0101, 1'b0);

        // reset during back-to-back single-cycle ops
        drv(2'b00, 6'd0, 5'd0, 32'd20, 32'd22);
        step();
        chk("b2b.res", 64'(result), 64'd42);
        drv(2'b10, 6'b100101, 5'd0, 32'h5, 32'hA);
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        chk_reset("rstb2b");
        rst = 1'b0;
        step();
        chk("post.ov", 64'(out_valid), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
